// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one byte-wide UART transmitter between two N-bit requesters.
//   A captured word is sent MSB byte first as N/8 one-cycle strobes. Each
//   strobe waits for the UART busy flag to be low. After a strobe the block
//   waits for the flag to rise and then fall. If the flag never rises within
//   START_WAIT cycles, the byte is treated as sent so the sequencer cannot hang.
//   When both requesters are valid, the one not served last wins (round-robin).
//
// Ports
//   iCE_CLK          system clock, rising edge
//   rst              asynchronous active-high reset
//   req0_valid/data  requester 0 word, held until req0_ack
//   req0_ack         one-cycle pulse, requester 0 word captured
//   req1_valid/data  requester 1 word, held until req1_ack
//   req1_ack         one-cycle pulse, requester 1 word captured
//   is_transmitting  UART TX busy flag (synchronous to iCE_CLK)
//   tx_byte          byte to the UART; holds its last value between strobes
//   tx_valid         one-cycle byte strobe
//   busy             word in progress
//   grant            requester owning the current or last word
//   word_done        one-cycle pulse after the last byte of a word completes
module uart_tx_arbiter #(
  parameter int N          = 16,
  parameter int START_WAIT = 15
) (
  input  logic         iCE_CLK,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  output logic         req0_ack,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  output logic         req1_ack,
  input  logic         is_transmitting,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  output logic         busy,
  output logic         grant,
  output logic         word_done
);

  localparam int NBYTES = N / 8;
  localparam int BW     = $clog2(NBYTES) + 1;
  localparam int TW     = $clog2(START_WAIT + 1);

  localparam logic [BW-1:0] BCNT_LAST = BW'(NBYTES);
  localparam logic [TW-1:0] TCNT_LAST = TW'(START_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t         state;
  logic [N-1:0]   shreg;
  logic [BW-1:0]  bcnt;
  logic [TW-1:0]  tcnt;
  logic           last;

  logic           pick;
  logic [N-1:0]   pick_data;

  // When both requesters are valid, the winner is the one not granted last.
  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid) begin
      pick = ~last;
    end else if (req1_valid) begin
      pick = 1'b1;
    end
    pick_data = pick ? req1_data : req0_data;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge iCE_CLK or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      tcnt      <= '0;
      last      <= 1'b1;
      grant     <= 1'b0;
      tx_byte   <= '0;
      tx_valid  <= 1'b0;
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      word_done <= 1'b0;
    end else begin
      tx_valid  <= 1'b0;
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      word_done <= 1'b0;

      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            shreg    <= pick_data;
            bcnt     <= '0;
            grant    <= pick;
            last     <= pick;
            req0_ack <= ~pick;
            req1_ack <= pick;
            state    <= SEND;
          end
        end

        SEND: begin
          if (!is_transmitting) begin
            tx_byte  <= shreg[N-1 -: 8];
            tx_valid <= 1'b1;
            shreg    <= shreg << 8;
            bcnt     <= bcnt + BW'(1);
            tcnt     <= '0;
            state    <= WAIT_START;
          end
        end

        WAIT_START: begin
          if (is_transmitting) begin
            state <= WAIT_DONE;
          end else if (tcnt == TCNT_LAST) begin
            // No busy rise seen: treat the byte as sent. The flag is known
            // low here, so the word-end rule of WAIT_DONE applies at once.
            if (bcnt == BCNT_LAST) begin
              word_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= SEND;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        WAIT_DONE: begin
          if (!is_transmitting) begin
            if (bcnt == BCNT_LAST) begin
              word_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N  = 16;
  localparam int SW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0v, r1v, r0a, r1a;
  logic [N-1:0] r0d, r1d;
  logic         uart_busy, hold_busy, is_t;
  logic [7:0]   tx_byte;
  logic         tx_valid, busy, grant, word_done;

  logic         w_r0v, w_r1v, w_r0a, w_r1a;
  logic [31:0]  w_r0d, w_r1d;
  logic         w_is_t;
  logic [7:0]   w_tx_byte;
  logic         w_tx_valid, w_busy, w_grant, w_done;

  assign is_t = uart_busy | hold_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .START_WAIT(SW)) dut (
    .iCE_CLK(clk), .rst(rst),
    .req0_valid(r0v), .req0_data(r0d), .req0_ack(r0a),
    .req1_valid(r1v), .req1_data(r1d), .req1_ack(r1a),
    .is_transmitting(is_t),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .busy(busy),
    .grant(grant), .word_done(word_done)
  );

  uart_tx_arbiter #(.N(32), .START_WAIT(15)) dut32 (
    .iCE_CLK(clk), .rst(rst),
    .req0_valid(w_r0v), .req0_data(w_r0d), .req0_ack(w_r0a),
    .req1_valid(w_r1v), .req1_data(w_r1d), .req1_ack(w_r1a),
    .is_transmitting(w_is_t),
    .tx_byte(w_tx_byte), .tx_valid(w_tx_valid), .busy(w_busy),
    .grant(w_grant), .word_done(w_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard queues, filled by the stimulus from the reference model.
  int         exp_ack[$];
  logic [7:0] exp_byte[$];
  int         exp_done[$];
  logic [7:0] q32[$];
  int         model_last = 1;
  int         uart_mode = 0;   // 0: UART answers each strobe, 1: UART silent
  int         w_dones = 0;

  int   cyc = 0;
  logic ist_edge = 1'b0;
  int   last_strobe = 0;
  int   nbytes = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ist_edge <= is_t;
  end

  // UART model for the 16-bit instance: busy rises one cycle after a strobe.
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid && uart_mode == 0) begin
        @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  initial begin
    w_is_t = 1'b0;
    forever begin
      @(negedge clk);
      if (w_tx_valid) begin
        @(posedge clk);
        #1 w_is_t = 1'b1;
        repeat (3) @(posedge clk);
        #1 w_is_t = 1'b0;
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      nbytes = 0;
    end else begin
      if (r0a || r1a) begin
        if (exp_ack.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack actual=%b%b expected=none", r1a, r0a);
        end else begin
          int id;
          id = exp_ack.pop_front();
          check("ack_onehot", {r1a, r0a}, (id == 0) ? 32'd1 : 32'd2);
          check("busy_at_ack", busy, 1);
        end
      end
      if (tx_valid) begin
        if (exp_byte.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe actual=%0h expected=none", tx_byte);
        end else begin
          check("tx_byte", tx_byte, exp_byte.pop_front());
        end
        check("no_strobe_while_busy", ist_edge, 0);
        if (nbytes > 0) begin
          if (uart_mode == 1) check("timeout_gap", cyc - last_strobe, SW + 1);
          else                check("min_gap", (cyc - last_strobe) >= 3, 1);
        end
        last_strobe = cyc;
        nbytes++;
      end
      if (word_done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          check("done_grant", grant, exp_done.pop_front());
        end
        check("done_busy", busy, 0);
        check("bytes_per_word", nbytes, N / 8);
        if (uart_mode == 1) check("timeout_done_gap", cyc - last_strobe, SW);
        nbytes = 0;
      end
    end
  end

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (w_r0a || w_r1a) check("w_ack", {w_r1a, w_r0a}, 2);
      if (w_tx_valid) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected_strobe actual=%0h expected=none", w_tx_byte);
        end else begin
          check("w_tx_byte", w_tx_byte, q32.pop_front());
        end
      end
      if (w_done) begin
        w_dones++;
        check("w_done_grant", w_grant, 1);
      end
    end
  end

  // Reference model: decides service order from the round-robin rule and
  // queues the acks, bytes (MSB first) and done pulses that must follow.
  task automatic issue(input bit u0, input bit u1, input logic [N-1:0] d0, input logic [N-1:0] d1);
    int order[2];
    int cnt;
    cnt = 0;
    if (u0 && u1) begin
      order[0] = (model_last == 0) ? 1 : 0;
      order[1] = 1 - order[0];
      cnt = 2;
    end else begin
      order[0] = u1 ? 1 : 0;
      cnt = 1;
    end
    for (int k = 0; k < cnt; k++) begin
      logic [N-1:0] w;
      w = (order[k] == 1) ? d1 : d0;
      exp_ack.push_back(order[k]);
      for (int b = N / 8 - 1; b >= 0; b--) exp_byte.push_back(w[b*8 +: 8]);
      exp_done.push_back(order[k]);
      model_last = order[k];
    end
    r0d = d0;
    r1d = d1;
    r0v = u0;
    r1v = u1;
  endtask

  task automatic serve(input int budget);
    int n;
    n = 0;
    while ((exp_done.size() != 0 || r0v || r1v || is_t) && n < budget) begin
      @(posedge clk);
      #1;
      if (r0a) r0v = 1'b0;
      if (r1a) r1v = 1'b0;
      n++;
    end
    check("serve_in_time", n < budget, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    r0v = 0; r1v = 0; r0d = '0; r1d = '0; hold_busy = 1'b0;
    w_r0v = 0; w_r1v = 0; w_r0d = '0; w_r1d = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {tx_byte, tx_valid, busy, grant, word_done, r0a, r1a}, 0);
    check("w_reset_outputs", {w_tx_byte, w_tx_valid, w_busy, w_grant, w_done, w_r0a, w_r1a}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Contention straight after reset, then re-armed.
    uart_mode = 0;
    issue(1, 1, 16'h1111, 16'h2222);
    serve(400);
    issue(1, 1, 16'h3333, 16'h4444);
    serve(400);

    // Single word.
    issue(1, 0, 16'hA55A, 16'h0000);
    serve(400);

    // UART already busy at capture.
    hold_busy = 1'b1;
    issue(1, 0, 16'hA55A, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (r0a) r0v = 1'b0;
    end
    check("held_no_strobe", exp_byte.size(), 2);
    hold_busy = 1'b0;
    serve(400);

    // Timeout path: UART never raises busy.
    uart_mode = 1;
    issue(0, 1, 16'hC33C, 16'h0F0F);
    serve(400);
    uart_mode = 0;

    // Randomized traffic.
    for (int e = 0; e < 24; e++) begin
      int sel;
      sel = $urandom_range(1, 3);
      uart_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      issue(sel[0], sel[1], N'($urandom), N'($urandom));
      serve(600);
    end
    uart_mode = 0;

    // Reset in the middle of a word.
    issue(1, 0, 16'hBEEF, 16'h0000);
    begin
      int n;
      n = 0;
      while (exp_byte.size() != 1 && n < 200) begin
        @(posedge clk); #2;
        if (r0a) r0v = 1'b0;
        n++;
      end
      check("first_strobe_seen", n < 200, 1);
    end
    rst = 1'b1;
    #1;
    check("midword_reset_outputs", {tx_byte, tx_valid, busy, grant, word_done, r0a, r1a}, 0);
    exp_ack.delete();
    exp_byte.delete();
    exp_done.delete();
    model_last = 1;
    r0v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    issue(0, 1, 16'h0000, 16'h5AA5);
    serve(400);
    issue(1, 1, 16'h1234, 16'h5678);
    serve(400);

    // 32-bit instance: four bytes from requester 1.
    q32.push_back(8'hDE);
    q32.push_back(8'hAD);
    q32.push_back(8'hBE);
    q32.push_back(8'hEF);
    w_r1d = 32'hDEADBEEF;
    w_r1v = 1'b1;
    begin
      int n;
      n = 0;
      while ((w_dones == 0 || w_is_t) && n < 400) begin
        @(posedge clk); #1;
        if (w_r1a) w_r1v = 1'b0;
        n++;
      end
      check("w_in_time", n < 400, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("w_dones", w_dones, 1);
    check("w_queue_empty", q32.size(), 0);
    check("w_idle", w_busy, 0);

    check("scoreboard_drained", exp_byte.size() + exp_ack.size() + exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
